// File: rtl/key_sw_debounce.sv
// Key/switch input conditioning: 2-FF sync, tick-based debounce, key
// press/release pulses, sticky press flags and a maskable interrupt.

// Per-channel synchroniser and stability counter. The debounced level lives
// in the parent; this block only reports when that level should flip.
module key_sw_db_chan #(
  parameter int   STABLE_TICKS = 20,
  parameter logic RST_VAL      = 1'b0
) (
  input  logic lb_clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic pad_i,
  input  logic db_i,
  output logic acc_o
);
  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where sync agrees with db restarts the count; mismatching ticks
  // advance it, and the last one accepts the new level.
  always_comb begin
    acc_o = 1'b0;
    cnt_d = cnt_q;
    if (s2_q == db_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CW'(STABLE_TICKS - 1)) begin
        acc_o = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser and counter state; reset puts sync at the idle level.
  always_ff @(posedge lb_clk) begin
    if (!rst_n) begin
      s1_q  <= RST_VAL;
      s2_q  <= RST_VAL;
      cnt_q <= '0;
    end else begin
      s1_q  <= pad_i;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

module key_sw_debounce #(
  parameter int NUM_KEY      = 4,
  parameter int NUM_SW       = 3,
  parameter int TICK_DIV     = 12000,
  parameter int STABLE_TICKS = 20
) (
  input  logic               lb_clk,
  input  logic               rst_n,
  input  logic [NUM_KEY-1:0] key_pad_n,
  input  logic [NUM_SW-1:0]  sw_pad,
  output logic [NUM_KEY-1:0] key_db_n,
  output logic [NUM_SW-1:0]  sw_db,
  output logic [NUM_KEY-1:0] key_press_pulse,
  output logic [NUM_KEY-1:0] key_release_pulse,
  output logic [NUM_KEY-1:0] key_evt,
  input  logic [NUM_KEY-1:0] evt_clr,
  input  logic [NUM_KEY-1:0] irq_en,
  output logic               irq
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]      pre_q, pre_d;
  logic               tick;
  logic [NUM_KEY-1:0] key_acc, key_db_q, key_db_d;
  logic [NUM_SW-1:0]  sw_acc, sw_db_q, sw_db_d;
  logic [NUM_KEY-1:0] press_q, press_d, rel_q, rel_d, evt_q, evt_d;

  // Free-running prescaler; tick is its terminal count.
  always_comb begin
    tick  = (pre_q == PW'(TICK_DIV - 1));
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  for (genvar g = 0; g < NUM_KEY; g++) begin : g_key
    key_sw_db_chan #(.STABLE_TICKS(STABLE_TICKS), .RST_VAL(1'b1)) u_chan (
      .lb_clk (lb_clk),
      .rst_n  (rst_n),
      .tick_i (tick),
      .pad_i  (key_pad_n[g]),
      .db_i   (key_db_q[g]),
      .acc_o  (key_acc[g])
    );
  end

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    key_sw_db_chan #(.STABLE_TICKS(STABLE_TICKS), .RST_VAL(1'b0)) u_chan (
      .lb_clk (lb_clk),
      .rst_n  (rst_n),
      .tick_i (tick),
      .pad_i  (sw_pad[g]),
      .db_i   (sw_db_q[g]),
      .acc_o  (sw_acc[g])
    );
  end

  // Accept flips the level; the pulse direction follows the pre-flip level so
  // pulse and new level appear in the same cycle. Press set beats clear.
  always_comb begin
    key_db_d = key_db_q ^ key_acc;
    sw_db_d  = sw_db_q ^ sw_acc;
    press_d  = key_acc & key_db_q;
    rel_d    = key_acc & ~key_db_q;
    evt_d    = press_q | (evt_q & ~evt_clr);
  end

  // Output-side state.
  always_ff @(posedge lb_clk) begin
    if (!rst_n) begin
      pre_q    <= '0;
      key_db_q <= '1;
      sw_db_q  <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      evt_q    <= '0;
    end else begin
      pre_q    <= pre_d;
      key_db_q <= key_db_d;
      sw_db_q  <= sw_db_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      evt_q    <= evt_d;
    end
  end

  assign key_db_n          = key_db_q;
  assign sw_db             = sw_db_q;
  assign key_press_pulse   = press_q;
  assign key_release_pulse = rel_q;
  assign key_evt           = evt_q;
  assign irq               = |(evt_q & irq_en);
endmodule

// File: tb/tb_key_sw_debounce.sv
// Bench for key_sw_debounce: directed scenarios plus random pad activity,
// compared every cycle against a timestamp-based reference model.
module tb_key_sw_debounce;
  localparam int TD = 4, ST = 3, NK = 4, NS = 3, NCH = 7, HN = 8192;

  logic          lb_clk = 1'b0, rst_n = 1'b0;
  logic [NK-1:0] key_pad_n = '1, evt_clr = '0, irq_en = '0;
  logic [NS-1:0] sw_pad = '0;
  logic [NK-1:0] key_db_n, key_press_pulse, key_release_pulse, key_evt;
  logic [NS-1:0] sw_db;
  logic          irq;

  logic [NK-1:0] key_pad_n2 = '1, evt_clr2 = '0, irq_en2 = '1;
  logic [NS-1:0] sw_pad2 = '0;
  logic [NK-1:0] key_db_n2, press2, rel2, evt2;
  logic [NS-1:0] sw_db2;
  logic          irq2;

  key_sw_debounce #(.NUM_KEY(NK), .NUM_SW(NS), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .lb_clk(lb_clk), .rst_n(rst_n), .key_pad_n(key_pad_n), .sw_pad(sw_pad),
    .key_db_n(key_db_n), .sw_db(sw_db), .key_press_pulse(key_press_pulse),
    .key_release_pulse(key_release_pulse), .key_evt(key_evt), .evt_clr(evt_clr),
    .irq_en(irq_en), .irq(irq));

  key_sw_debounce #(.NUM_KEY(NK), .NUM_SW(NS), .TICK_DIV(1), .STABLE_TICKS(1)) dut2 (
    .lb_clk(lb_clk), .rst_n(rst_n), .key_pad_n(key_pad_n2), .sw_pad(sw_pad2),
    .key_db_n(key_db_n2), .sw_db(sw_db2), .key_press_pulse(press2),
    .key_release_pulse(rel2), .key_evt(evt2), .evt_clr(evt_clr2),
    .irq_en(irq_en2), .irq(irq2));

  always #5 lb_clk = ~lb_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0, errors = 0;

  // Reference model: a channel flips when, since the last cycle its
  // synchronised input agreed with the level, ST prescaler ticks have elapsed.
  bit            hist [NCH][HN];
  bit            m_db [NCH];
  int            m_lm [NCH];
  int            m_n;
  logic [NK-1:0] m_press, m_rel, m_evt;

  function automatic int nticks(int a, int b);
    if (b < a) return 0;
    return (b + 1) / TD - a / TD;
  endfunction

  task automatic model_edge();
    logic [NK-1:0] np, nr;
    bit pad, sv, rv;
    if (!rst_n) begin
      m_n = 0;
      for (int c = 0; c < NCH; c++) begin m_db[c] = (c < NK); m_lm[c] = -1; end
      m_press = '0; m_rel = '0; m_evt = '0;
      return;
    end
    np = '0; nr = '0;
    m_evt = m_press | (m_evt & ~evt_clr);
    for (int c = 0; c < NCH; c++) begin
      rv  = (c < NK);
      pad = (c < NK) ? key_pad_n[c] : sw_pad[c-NK];
      hist[c][m_n % HN] = pad;
      sv  = (m_n >= 2) ? hist[c][(m_n-2) % HN] : rv;
      if (sv == m_db[c]) m_lm[c] = m_n;
      else if ((m_n % TD) == TD-1 && nticks(m_lm[c]+1, m_n) == ST) begin
        m_db[c] = sv;
        m_lm[c] = m_n;
        if (c < NK) begin
          if (!sv) np[c] = 1'b1; else nr[c] = 1'b1;
        end
      end
    end
    m_press = np; m_rel = nr;
    m_n++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [NK-1:0] mk;
    logic [NS-1:0] ms;
    @(posedge lb_clk);
    model_edge();
    @(negedge lb_clk);
    for (int c = 0; c < NK; c++) mk[c] = m_db[c];
    for (int c = 0; c < NS; c++) ms[c] = m_db[NK+c];
    check("key_db_n", 32'(key_db_n), 32'(mk));
    check("sw_db", 32'(sw_db), 32'(ms));
    check("press", 32'(key_press_pulse), 32'(m_press));
    check("release", 32'(key_release_pulse), 32'(m_rel));
    check("key_evt", 32'(key_evt), 32'(m_evt));
    check("irq", 32'(irq), 32'(|(m_evt & irq_en)));
    check("dut2_keys_quiet", 32'({key_db_n2, press2, rel2, evt2, irq2}), 32'({4'hF, 13'h0}));
  endtask

  int k, pc, rc, hold[NCH];
  bit found;

  initial begin
    rst_n = 1'b0;
    repeat (3) cyc();
    check("rst_key_db_n", 32'(key_db_n), 32'hF);
    check("rst_sw_db", 32'(sw_db), 32'h0);
    check("rst_evt_irq", 32'({key_evt, key_press_pulse, key_release_pulse, irq}), 32'h0);
    rst_n = 1'b1;

    // TICK_DIV=1, STABLE_TICKS=1 switch: exactly 3 cycles
    sw_pad2[2] = 1'b1;
    cyc(); cyc();
    check("t6_sw_db2_at2", 32'(sw_db2[2]), 32'h0);
    cyc();
    check("t6_sw_db2_at3", 32'(sw_db2[2]), 32'h1);
    repeat (4) cyc();

    // Clean press on key 0
    irq_en = 4'b0001;
    key_pad_n[0] = 1'b0;
    k = 0;
    while (key_db_n[0] && k < 40) begin cyc(); k++; end
    check("t1_latency_in_11_15", 32'(k >= 11 && k <= 15), 32'h1);
    check("t1_press_pulse", 32'(key_press_pulse[0]), 32'h1);
    cyc();
    check("t1_press_gone", 32'(key_press_pulse[0]), 32'h0);
    check("t1_evt", 32'(key_evt[0]), 32'h1);
    check("t1_irq", 32'(irq), 32'h1);
    evt_clr = 4'b0001; cyc(); evt_clr = '0; cyc();
    check("t1_cleared", 32'({key_evt[0], irq}), 32'h0);

    // Bounce on key 3
    pc = 0; rc = 0;
    for (int i = 0; i < 40; i++) begin
      key_pad_n[3] = ((i / 5) % 2 == 1);
      cyc(); pc += key_press_pulse[3]; rc += key_release_pulse[3];
    end
    key_pad_n[3] = 1'b0;
    repeat (30) begin cyc(); pc += key_press_pulse[3]; rc += key_release_pulse[3]; end
    check("t2_press_cnt", 32'(pc), 32'd1);
    check("t2_release_cnt", 32'(rc), 32'd0);
    check("t2_level", 32'(key_db_n[3]), 32'h0);

    // Glitch high on a debounced key
    pc = 0; rc = 0;
    key_pad_n[3] = 1'b1;
    repeat (6) begin cyc(); pc += key_press_pulse[3]; rc += key_release_pulse[3]; end
    key_pad_n[3] = 1'b0;
    repeat (20) begin cyc(); pc += key_press_pulse[3]; rc += key_release_pulse[3]; end
    check("t3_pulses", 32'(pc + rc), 32'd0);
    check("t3_level", 32'(key_db_n[3]), 32'h0);

    // Clear coincident with press pulse on key 1
    evt_clr = '1; cyc(); evt_clr = '0;
    irq_en = 4'b0010;
    key_pad_n[1] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc();
      found = key_press_pulse[1];
    end
    check("t4_pulse_seen", 32'(found), 32'h1);
    evt_clr = 4'b0010;
    cyc();
    check("t4_set_wins", 32'({key_evt[1], irq}), 32'h3);
    cyc();
    check("t4_clr", 32'({key_evt[1], irq}), 32'h0);
    evt_clr = '0;

    // Reset two ticks into a press on key 2
    key_pad_n[2] = 1'b0;
    repeat (10) cyc();
    check("t5_not_yet", 32'(key_db_n[2]), 32'h1);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    check("t5_rst_level", 32'(key_db_n), 32'hF);
    check("t5_rst_no_pulse", 32'({key_press_pulse, key_release_pulse}), 32'h0);
    k = 0;
    while (key_db_n[2] && k < 40) begin cyc(); k++; end
    check("t5_fresh_latency", 32'(k), 32'd12);

    // Random activity on all channels
    for (int c = 0; c < NCH; c++) hold[c] = $urandom_range(1, 20);
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          if (c < NK) key_pad_n[c] = ~key_pad_n[c]; else sw_pad[c-NK] = ~sw_pad[c-NK];
          hold[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(14, 30) : $urandom_range(1, 8);
        end else hold[c]--;
      end
      evt_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      if (i % 64 == 0) irq_en = 4'($urandom);
      rst_n = ($urandom_range(0, 999) != 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
